hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Issuing end of the pipeline flush/stall interface: generates the synchronous-clear (syn_reset)
//  and hold controls consumed by IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
//  Resolves load-use, EX redirect, multicycle-unit waits and MEM traps, with priority, in one FSM.
// PARAMETERS
//  REG_ADDR_W   5   register index width
//  MC_TIMEOUT   64  max MC_WAIT cycles before the multicycle op is killed (>=2)
//  DRAIN_CYC    2   IF/ID flush cycles held after a trap (>=1)
//  CNT_W        32  perf counter width (HAZARD_PERF_EN only)
// PORTS
//  clk          in  1           core clock
//  reset        in  1           synchronous, active-high
//  id_rs1       in  REG_ADDR_W  ID source reg 1
//  id_rs2       in  REG_ADDR_W  ID source reg 2
//  id_use_rs1   in  1           ID instr reads rs1
//  id_use_rs2   in  1           ID instr reads rs2
//  ex_load      in  1           EX instr is a load
//  ex_rd        in  REG_ADDR_W  EX destination reg
//  ex_redirect  in  1           EX resolved a taken branch/jump
//  mc_start     in  1           multicycle op (div) entering execution in EX
//  mc_done      in  1           multicycle result valid this cycle
//  mem_trap     in  1           MEM stage raises a trap
//  pc_stall     out 1           hold PC
//  ifid_stall   out 1           hold IF/ID
//  idex_stall   out 1           hold ID/EX
//  ifid_flush   out 1           syn_reset of IF/ID
//  idex_flush   out 1           syn_reset of ID/EX
//  exmem_flush  out 1           syn_reset of EX/MEM
//  mc_kill      out 1           abort multicycle unit (1-cycle pulse)
//  mc_timeout   out 1           timeout flag (1-cycle pulse)
//  stall_cnt    out CNT_W       cycles with pc_stall=1 (0 without macro)
//  flush_cnt    out CNT_W       cycles with any flush=1 (0 without macro)
// BEHAVIOUR
//  - State and counters registered; all outputs combinational from state+inputs (0-cycle latency).
//  - reset=1: state->RUN, counters->0; while asserted: all three flushes=1, stalls/pulses=0.
//  - load_use = ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - RUN, priority top-down (first match only):
//    mem_trap: all flushes=1; drain_cnt<=DRAIN_CYC-1 (DRAIN_CYC=1: stay RUN); else ->TRAP_DRAIN.
//    ex_redirect: ifid_flush=idex_flush=1; stay RUN.
//    mc_start & !mc_done: pc/ifid/idex_stall=1, exmem_flush=1; mc_cnt<=0; ->MC_WAIT.
//    load_use: pc_stall=ifid_stall=1, idex_flush=1 (one bubble); stay RUN.
//    mc_start & mc_done same cycle: no action.
//  - MC_WAIT: default pc/ifid/idex_stall=1, exmem_flush=1, mc_cnt++.
//    mem_trap: all flushes=1, stalls=0, mc_kill=1, ->TRAP_DRAIN. ex_redirect ignored.
//    mc_done (no trap): stalls=0, exmem_flush=0 that cycle; ->RUN.
//    mc_cnt==MC_TIMEOUT-1 & !mc_done: mc_timeout=mc_kill=1, idex_flush=1, stalls=0; ->RUN.
//  - TRAP_DRAIN: ifid_flush=1; drain_cnt-- ; at 0 -> RUN. New mem_trap reloads drain_cnt.
//  - Stall and flush of the same register never both asserted; flush wins.
// CONFIGURATION
//  HAZARD_PERF_EN defined: stall_cnt/flush_cnt increment per qualifying cycle, saturate at
//  all-ones, clear on reset. Undefined: counters not built, ports tied to 0, ports kept.
// STRUCTURE
//  hazard_pkg: hz_state_t enum {RUN, MC_WAIT, TRAP_DRAIN}, REG_X0 constant, default widths.
//  Sub-module hazard_sat_cnt (saturating, sync reset) instantiated twice under HAZARD_PERF_EN.
// TESTING
//  ex_load=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> 1 cycle pc_stall=ifid_stall=idex_flush=1; ex_rd=0 -> none.
//  ex_redirect=1 together with load_use -> ifid_flush=idex_flush=1, pc_stall=0.
//  mc_start, mc_done after 10 cycles -> stalls+exmem_flush high 10 cycles, all low on done cycle.
//  mc_start, no done, MC_TIMEOUT=8 -> mc_timeout=mc_kill=1 on 8th MC_WAIT cycle, then RUN.
//  mem_trap during MC_WAIT -> all flushes+mc_kill same cycle, ifid_flush 2 more cycles (DRAIN_CYC=2).
//  reset mid-MC_WAIT -> flushes=1 during reset, RUN after; perf counters 0, saturate at 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MC_WAIT    = 2'd1,
        TRAP_DRAIN = 2'd2
    } hz_state_t;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned MC_TIMEOUT_DEF = 64;
    localparam int unsigned DRAIN_CYC_DEF  = 2;
    localparam int unsigned CNT_W_DEF      = 32;

    // Hard-wired zero register; never a real dependency.
    localparam int unsigned REG_X0 = 0;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic mc_kill;
        logic mc_timeout;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
module hazard_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, redirect, multicycle wait and trap drain.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  mem_trap,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mc_kill,
    output logic                  mc_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned MC_CNT_W = $clog2(MC_TIMEOUT);
    localparam int unsigned DRAIN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [MC_CNT_W-1:0] MC_LAST    = MC_CNT_W'(MC_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    // A single-cycle drain is fully covered by the trap cycle itself.
    localparam hz_state_t           TRAP_NEXT  = (DRAIN_CYC > 1) ? TRAP_DRAIN : RUN;

    hz_state_t             state_q, state_d;
    logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    hz_ctrl_t              ctrl_c;
    logic                  load_use_c;

    assign load_use_c = ex_load && (ex_rd != REG_ADDR_W'(REG_X0)) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ctrl_c      = '0;

        if (reset) begin
            ctrl_c.ifid_flush  = 1'b1;
            ctrl_c.idex_flush  = 1'b1;
            ctrl_c.exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_trap) begin
                        ctrl_c.ifid_flush  = 1'b1;
                        ctrl_c.idex_flush  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        drain_cnt_d        = DRAIN_LAST;
                        state_d            = TRAP_NEXT;
                    end else if (ex_redirect) begin
                        ctrl_c.ifid_flush = 1'b1;
                        ctrl_c.idex_flush = 1'b1;
                    end else if (mc_start && !mc_done) begin
                        ctrl_c.pc_stall    = 1'b1;
                        ctrl_c.ifid_stall  = 1'b1;
                        ctrl_c.idex_stall  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        mc_cnt_d           = '0;
                        state_d            = MC_WAIT;
                    end else if (load_use_c) begin
                        ctrl_c.pc_stall   = 1'b1;
                        ctrl_c.ifid_stall = 1'b1;
                        ctrl_c.idex_flush = 1'b1;
                    end
                end

                MC_WAIT: begin
                    // Redirects cannot occur while EX is occupied by the multicycle op.
                    if (mem_trap) begin
                        ctrl_c.ifid_flush  = 1'b1;
                        ctrl_c.idex_flush  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        ctrl_c.mc_kill     = 1'b1;
                        drain_cnt_d        = DRAIN_LAST;
                        state_d            = TRAP_NEXT;
                    end else if (mc_done) begin
                        state_d = RUN;
                    end else if (mc_cnt_q == MC_LAST) begin
                        ctrl_c.mc_timeout  = 1'b1;
                        ctrl_c.mc_kill     = 1'b1;
                        ctrl_c.idex_flush  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        state_d            = RUN;
                    end else begin
                        ctrl_c.pc_stall    = 1'b1;
                        ctrl_c.ifid_stall  = 1'b1;
                        ctrl_c.idex_stall  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        mc_cnt_d           = mc_cnt_q + MC_CNT_W'(1);
                    end
                end

                TRAP_DRAIN: begin
                    if (mem_trap) begin
                        ctrl_c.ifid_flush  = 1'b1;
                        ctrl_c.idex_flush  = 1'b1;
                        ctrl_c.exmem_flush = 1'b1;
                        drain_cnt_d        = DRAIN_LAST;
                        state_d            = TRAP_NEXT;
                    end else begin
                        ctrl_c.ifid_flush = 1'b1;
                        if (drain_cnt_q == '0) begin
                            state_d = RUN;
                        end else begin
                            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign pc_stall    = ctrl_c.pc_stall;
    assign ifid_stall  = ctrl_c.ifid_stall;
    assign idex_stall  = ctrl_c.idex_stall;
    assign ifid_flush  = ctrl_c.ifid_flush;
    assign idex_flush  = ctrl_c.idex_flush;
    assign exmem_flush = ctrl_c.exmem_flush;
    assign mc_kill     = ctrl_c.mc_kill;
    assign mc_timeout  = ctrl_c.mc_timeout;

`ifdef HAZARD_PERF_EN
    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (ctrl_c.pc_stall),
        .cnt_o (stall_cnt)
    );

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (ctrl_c.ifid_flush | ctrl_c.idex_flush | ctrl_c.exmem_flush),
        .cnt_o (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
